// File: rtl/simu_uart_pkg.sv
// Shared constants and types for the simulation UART console monitor:
// APB snoop-bus field offsets, UART register offsets and the FIFO entry layout.
package simu_uart_pkg;

  localparam logic [3:0] THR_ADDR = 4'h0;
  localparam logic [3:0] LCR_ADDR = 4'h3;

  localparam int PWDATA_LSB  = 96;
  localparam int PADDR_LSB   = 64;
  localparam int PWRITE_BIT  = 32;
  localparam int PENABLE_BIT = 0;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {
    SRC_APB  = 1'b0,
    SRC_CONF = 1'b1
  } src_e;

  typedef struct packed {
    src_e       src;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/simu_uart_fifo.sv
// Synchronous DEPTH-entry FIFO of {src, byte} entries; the head entry is read
// straight from storage so a push becomes visible the cycle after it lands.
module simu_uart_fifo
  import simu_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  fifo_entry_t i_push_data,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_level
);

  fifo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // NOTE: the storage array is deliberately not reset; pointers and level alone
  // define which entries are live, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/simu_uart_monitor.sv
// Simulation console sink: snoops UART THR writes and confreg console bytes,
// merges them into one FIFO for the harness, and tracks line and drop stats.
module simu_uart_monitor #(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter logic [3:0] THR_ADDR = simu_uart_pkg::THR_ADDR,
  parameter logic [3:0] LCR_ADDR = simu_uart_pkg::LCR_ADDR
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [127:0]  uart_ctr_bus,
  input  logic          write_uart_valid,
  input  logic [7:0]    confreg_uart_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_src,
  output logic          line_done,
  output logic [15:0]   line_len,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   overflow_cnt
);

  import simu_uart_pkg::*;

  logic [31:0] w_pwdata;
  logic [3:0]  w_paddr;
  logic        w_pwrite;
  logic        w_penable;
  logic        w_unused_bus;

  assign w_pwdata  = uart_ctr_bus[PWDATA_LSB +: 32];
  assign w_paddr   = uart_ctr_bus[PADDR_LSB +: 4];
  assign w_pwrite  = uart_ctr_bus[PWRITE_BIT];
  assign w_penable = uart_ctr_bus[PENABLE_BIT];
  assign w_unused_bus = ^{uart_ctr_bus[PWDATA_LSB-1:PADDR_LSB+4],
                          uart_ctr_bus[PADDR_LSB-1:PWRITE_BIT+1],
                          uart_ctr_bus[PWRITE_BIT-1:PENABLE_BIT+1],
                          w_pwdata[31:8]};

  logic        r_acc_q;
  logic        r_dlab;
  logic        r_skid_valid;
  logic [7:0]  r_skid_data;
  logic        r_line_done;
  logic [15:0] r_line_len;
  logic [15:0] r_ovf_cnt;

  logic        w_acc_rise;
  logic        w_thr_wr;
  logic        w_lcr_wr;
  logic        w_pop;
  logic        w_room;
  logic        w_push;
  logic        w_skid_push;
  logic [1:0]  w_drops;
  logic [16:0] w_ovf_sum;
  fifo_entry_t w_push_data;
  fifo_entry_t w_head;
  logic        w_full;
  logic        w_empty;

  // A held PENABLE is one access; only its first cycle captures.
  assign w_acc_rise = w_penable & w_pwrite & ~r_acc_q;
  assign w_thr_wr   = w_acc_rise & (w_paddr == THR_ADDR) & ~r_dlab;
  assign w_lcr_wr   = w_acc_rise & (w_paddr == LCR_ADDR);

  assign w_pop  = ~w_empty & out_ready;
  assign w_room = ~w_full | w_pop;

  // NOTE: every signal written here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_push      = 1'b0;
    w_skid_push = 1'b0;
    w_push_data = '{src: SRC_APB, data: w_pwdata[7:0]};
    w_drops     = 2'd0;
    if (w_thr_wr) begin
      if (w_room) w_push = 1'b1;
      else        w_drops = w_drops + 2'd1;
    end else if (r_skid_valid && w_room) begin
      w_push      = 1'b1;
      w_skid_push = 1'b1;
      w_push_data = '{src: SRC_CONF, data: r_skid_data};
    end
    // A fresh console byte replacing an unsent skid byte loses the old one.
    if (write_uart_valid && r_skid_valid && !w_skid_push) w_drops = w_drops + 2'd1;
  end

  assign w_ovf_sum = {1'b0, r_ovf_cnt} + {15'd0, w_drops};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_acc_q      <= 1'b0;
      r_dlab       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= 8'h00;
      r_line_done  <= 1'b0;
      r_line_len   <= 16'h0000;
      r_ovf_cnt    <= 16'h0000;
    end else begin
      r_acc_q <= w_penable & w_pwrite;
      if (w_lcr_wr) r_dlab <= w_pwdata[7];

      if (write_uart_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= confreg_uart_data;
      end else if (w_skid_push) begin
        r_skid_valid <= 1'b0;
      end

      r_line_done <= w_pop & (w_head.data == ASCII_LF);
      if (w_pop) begin
        if (w_head.data == ASCII_LF)    r_line_len <= 16'h0000;
        else if (r_line_len != 16'hFFFF) r_line_len <= r_line_len + 16'd1;
      end

      r_ovf_cnt <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
    end
  end

  simu_uart_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (aclk),
    .rst_n       (aresetn),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  assign out_valid    = ~w_empty;
  assign out_data     = w_empty ? 8'h00 : w_head.data;
  assign out_src      = w_empty ? 1'b0  : w_head.src;
  assign line_done    = r_line_done;
  assign line_len     = r_line_len;
  assign overflow_cnt = r_ovf_cnt;

endmodule

// File: doc/simu_uart_monitor.md
Name: simu_uart_monitor

Overview:
- Simulation-only sink downstream of the Verilator top. Consumes the packed UART APB snoop bus `uart_ctr_bus` and the confreg console strobe (`write_uart_valid`, `confreg_uart_data`).
- Extracts transmitted characters from both sources and merges them into one FIFO. The C++ harness drains the FIFO through a valid/ready port.
- Reports line completion, line length and dropped-byte statistics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AW, 4, log2(DEPTH).
- THR_ADDR, 4'h0, UART transmit-holding register offset.
- LCR_ADDR, 4'h3, UART line-control register offset.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- uart_ctr_bus  in  128  snoop bus, fields:
  - [127:96] PWDATA
  - [67:64] PADDR[3:0]
  - [32] PWRITE
  - [0] PENABLE
- write_uart_valid  in  1  confreg console write strobe.
- confreg_uart_data  in  8  confreg console byte.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  harness accepts head.
- out_data  out  8  head byte.
- out_src  out  1  head origin: 0 = APB UART, 1 = confreg.
- line_done  out  1  one-cycle pulse when 0x0A is handed out.
- line_len  out  16  bytes handed out since last 0x0A, saturating.
- fifo_level  out  AW+1  current occupancy.
- overflow_cnt  out  16  dropped bytes, saturating at 16'hFFFF.

Behaviour:
- **Reset.** Synchronous on aclk with aresetn=0. All of the following clear to 0: out_valid, out_data, out_src, line_done, line_len, fifo_level, overflow_cnt, FIFO pointers, the dlab flag, the skid register and the PENABLE-edge register. Reset mid-operation discards FIFO contents and the skid byte.
- **APB decode.**
  - `acc = PENABLE & PWRITE`.
  - `acc_rise = acc & ~acc_q`, where acc_q is acc registered. Exactly one capture per access phase, even if PENABLE is held multiple cycles.
- **LCR write.** On acc_rise with PADDR==LCR_ADDR: dlab <= PWDATA[7].
- **THR write.** On acc_rise with PADDR==THR_ADDR and dlab==0: push byte PWDATA[7:0], src=0. When dlab==1 the write is a divisor-latch write and is ignored.
- **Confreg source.** write_uart_valid is sampled every cycle it is high (it is already a pulse) and loads the 1-entry skid register {valid, byte}.
- **Push arbitration, one push per cycle.**
  - An APB push has priority.
  - The skid byte pushes in any cycle with no APB push.
  - Skid valid plus a new confreg strobe in the same cycle: the new byte overwrites the skid, the old byte counts as dropped (overflow_cnt+1).
  - A skid push and a new strobe in the same cycle: the skid loads the new byte with no drop.
- **FIFO.**
  - Registered output, latency 1: a byte pushed in cycle N is visible on out_valid/out_data in cycle N+1 at earliest.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when full: allowed, with no drop.
  - Push when full and no pop: byte dropped, overflow_cnt+1.
  - A skid push blocked by full holds the skid (no drop) until space frees.
  - Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- **Output port.**
  - out_data and out_src stay stable while out_valid & ~out_ready.
  - out_valid drops only after a pop that empties the FIFO.
- **Line tracking (on pop).**
  - Popped byte 8'h0A: line_done=1 for the following cycle, line_len <= 0.
  - Any other byte: line_len+1, saturating at 16'hFFFF.
  - 8'h0D counts like any other byte.
- **Counters.** overflow_cnt and line_len saturate; they never wrap.

Decomposition:
- Shared package `simu_uart_pkg`:
  - THR_ADDR and LCR_ADDR constants.
  - Bus field offsets for uart_ctr_bus.
  - Character constants ASCII_LF=8'h0A and ASCII_CR=8'h0D.
  - Struct/typedef for a FIFO entry {src, data[7:0]}.
- One sub-module: `simu_uart_fifo`, a synchronous 9-bit-wide DEPTH-entry FIFO with push/pop/full/empty/level.
- Decode, skid, arbitration and line/overflow counters live in the top module.

Test Plan:
- **THR capture.** Reset. Then an APB THR write: PADDR=0, PWDATA=32'h48, PENABLE held 3 cycles.
  - Required: exactly one entry, out_data=8'h48, out_src=0, fifo_level=1.
- **Divisor latch.**
  1. LCR write PWDATA=8'h80, then THR write 8'h55: nothing pushed, fifo_level=0.
  2. LCR write 8'h03, then THR write 8'h41: out_data=8'h41.
- **Collision.** APB THR 8'h31 and confreg strobe 8'h32 in the same cycle, out_ready=1.
  - Required: output order 0x31 (src 0) then 0x32 (src 1); overflow_cnt=0.
- **Full FIFO.** out_ready=0, 17 APB THR writes of 0x00..0x10.
  - Required: fifo_level=16, overflow_cnt=1.
  - Then out_ready=1: bytes 0x00..0x0F emerge in order.
- **Line tracking.** Confreg bytes "ab\r\n" drained with out_ready=1.
  - Required: line_len steps 1,2,3, then 0; line_done high exactly one cycle, after the 0x0A pop.
- **Mid-operation reset.** 5 bytes queued, skid loaded, aresetn=0 for 1 cycle.
  - Required: next cycle out_valid=0, fifo_level=0, overflow_cnt=0, dlab=0; no stale byte appears afterwards.
